// File: rtl/cpu_pkg.sv
// Shared definitions for the vtisa core: opcode constants used by the decoder
// and the sequencer, plus the sequencer state encoding.
package cpu_pkg;

  // Opcodes live in instr[7:3].
  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LI   = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_ST   = 5'b00011;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_t;

  // LI only writes an immediate; every other EXEC-class opcode runs the ALU.
  function automatic logic op_uses_alu(input logic [4:0] op);
    return (op != OP_LI);
  endfunction

endpackage

// File: rtl/cpu_sequencer_seq_pc.sv
// Program counter: PC_W-bit register, async reset to RESET_PC, wrapping increment.
module seq_pc #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_inc,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // Advance by one on request; natural overflow gives the wrap to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit vtisa core. Owns PC and IR,
// drives the req/ack memory port and strobes the register file and ALU.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  input  logic [PC_W-1:0] data_addr,
  output logic [7:0]      ir,
  output logic            fetch_source,
  input  logic [4:0]      dec_opcode,
  input  logic            dec_is_mem_op,
  input  logic            dec_mem_rw,
  output logic [PC_W-1:0] pc,
  output logic            rf_we,
  output logic            alu_en,
  output logic            halted
);

  seq_state_t      r_state;
  seq_state_t      w_state_next;
  logic [7:0]      r_ir;
  logic [PC_W-1:0] w_pc;
  logic            w_pc_inc;
  logic            w_ir_load;

  seq_pc #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) u_seq_pc (
    .clk  (clk),
    .reset(reset),
    .i_inc(w_pc_inc),
    .o_pc (w_pc)
  );

  // State register; reset forces IDLE so every bus output drops at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Instruction register, captured from the read data on the fetch ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir <= 8'h00;
    end else if (w_ir_load) begin
      r_ir <= mem_rdata;
    end
  end

  // Next-state and Moore outputs. Outputs depend on the state (and on the
  // decoder, which only sees the stable IR), never on mem_ack; mem_ack only
  // steers the transition and the IR/PC updates.
  always_comb begin
    w_state_next = r_state;
    w_pc_inc     = 1'b0;
    w_ir_load    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    fetch_source = 1'b0;
    rf_we        = 1'b0;
    alu_en       = 1'b0;
    halted       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_addr     = w_pc;
        fetch_source = 1'b1;
        if (mem_ack) begin
          w_ir_load    = 1'b1;
          w_pc_inc     = 1'b1;
          w_state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // HALT is tested first so it can never be mistaken for another class.
        if (dec_opcode == OP_HALT) begin
          w_state_next = ST_HALT;
        end else if (dec_is_mem_op) begin
          w_state_next = ST_MEM;
        end else if (dec_opcode == OP_NOP) begin
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        rf_we        = 1'b1;
        alu_en       = op_uses_alu(dec_opcode);
        w_state_next = ST_FETCH;
      end

      ST_MEM: begin
        // Address and direction come from sources that are stable for the
        // whole instruction, so they stay constant across wait cycles.
        mem_req  = 1'b1;
        mem_we   = dec_mem_rw;
        mem_addr = data_addr;
        if (mem_ack) begin
          w_state_next = dec_mem_rw ? ST_FETCH : ST_WB;
        end
      end

      ST_WB: begin
        rf_we        = 1'b1;
        w_state_next = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign ir = r_ir;
  assign pc = w_pc;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: random programs with random wait
// states against an instruction-level protocol model, plus directed HALT,
// reset-abort and PC-wrap scenarios.
module tb_cpu_sequencer;

  localparam logic [4:0] K_NOP  = 5'h00;
  localparam logic [4:0] K_LI   = 5'h01;
  localparam logic [4:0] K_LD   = 5'h02;
  localparam logic [4:0] K_ST   = 5'h03;
  localparam logic [4:0] K_HALT = 5'h1F;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] data_addr = 8'h00;
  logic [7:0] ir;
  logic       fetch_source;
  logic [4:0] dec_opcode;
  logic       dec_is_mem_op, dec_mem_rw;
  logic [7:0] pc;
  logic       rf_we, alu_en, halted;

  logic       ff_mem_req, ff_mem_we, ff_fetch_source, ff_rf_we, ff_alu_en, ff_halted;
  logic [7:0] ff_mem_addr, ff_ir, ff_pc;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mem [256];
  logic [7:0] model_pc;

  always #5 clk = ~clk;

  // Bench-side decoder.
  assign dec_opcode    = ir[7:3];
  assign dec_is_mem_op = (ir[7:3] == K_LD) || (ir[7:3] == K_ST);
  assign dec_mem_rw    = (ir[7:3] == K_ST);

  cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .data_addr(data_addr),
    .ir(ir), .fetch_source(fetch_source),
    .dec_opcode(dec_opcode), .dec_is_mem_op(dec_is_mem_op), .dec_mem_rw(dec_mem_rw),
    .pc(pc), .rf_we(rf_we), .alu_en(alu_en), .halted(halted)
  );

  // Second instance: reset PC at the top of memory, zero-wait NOP memory.
  cpu_sequencer #(.PC_W(8), .RESET_PC(8'hFF)) dut_ff (
    .clk(clk), .reset(reset),
    .mem_req(ff_mem_req), .mem_we(ff_mem_we), .mem_addr(ff_mem_addr),
    .mem_ack(ff_mem_req), .mem_rdata(8'h00), .data_addr(8'h00),
    .ir(ff_ir), .fetch_source(ff_fetch_source),
    .dec_opcode(ff_ir[7:3]), .dec_is_mem_op(1'b0), .dec_mem_rw(1'b0),
    .pc(ff_pc), .rf_we(ff_rf_we), .alu_en(ff_alu_en), .halted(ff_halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks every Moore output for one cycle; address only matters with a request.
  task automatic chk_outs(input string tag, input logic e_req, input logic e_we,
                          input logic [7:0] e_addr, input logic e_src,
                          input logic e_rfwe, input logic e_alu, input logic e_halt);
    chk({tag, ".req"},    32'(mem_req),      32'(e_req));
    chk({tag, ".we"},     32'(mem_we),       32'(e_we));
    if (e_req) chk({tag, ".addr"}, 32'(mem_addr), 32'(e_addr));
    chk({tag, ".src"},    32'(fetch_source), 32'(e_src));
    chk({tag, ".rf_we"},  32'(rf_we),        32'(e_rfwe));
    chk({tag, ".alu_en"}, 32'(alu_en),       32'(e_alu));
    chk({tag, ".halted"}, 32'(halted),       32'(e_halt));
  endtask

  function automatic logic [7:0] rand_instr();
    logic [4:0] op;
    case ($urandom_range(0, 4))
      0:       op = K_NOP;
      1:       op = K_LI;
      2:       op = K_LD;
      3:       op = K_ST;
      default: op = 5'($urandom_range(4, 30));
    endcase
    return {op, 3'($urandom)};
  endfunction

  // Called at a falling edge; returns at the falling edge of the first FETCH cycle.
  task automatic do_reset();
    reset   = 1'b1;
    mem_ack = 1'b0;
    #1;
    chk_outs("rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.pc", 32'(pc), 32'h00);
    chk("rst.ir", 32'(ir), 32'h00);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    model_pc = 8'h00;
    #1;
    chk_outs("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'($urandom);
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  // Runs one instruction from model_pc. rst_at >= 0 asserts reset during the
  // MEM phase after that many wait cycles.
  task automatic run_instr(input int rst_at, output bit was_halt);
    logic [7:0] at, instr;
    logic [4:0] op;
    int         w;
    int         cyc;
    at       = model_pc;
    instr    = mem[at];
    op       = instr[7:3];
    was_halt = 1'b0;
    cyc      = 0;

    w = $urandom_range(0, 2);
    for (int k = 0; k <= w; k++) begin
      chk_outs("fetch", 1'b1, 1'b0, at, 1'b1, 1'b0, 1'b0, 1'b0);
      mem_ack   = (k == w);
      mem_rdata = (k == w) ? instr : 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    model_pc = at + 8'd1;

    chk_outs("decode", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("decode.ir", 32'(ir), 32'(instr));
    chk("decode.pc", 32'(pc), 32'(model_pc));
    data_addr = 8'($urandom);
    mem_ack   = 1'($urandom);
    mem_rdata = 8'($urandom);
    @(negedge clk);
    cyc++;
    mem_ack = 1'b0;

    if (op == K_HALT) begin
      for (int k = 0; k < 20; k++) begin
        chk_outs("halt", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        mem_ack = 1'($urandom);
        @(negedge clk);
        cyc++;
      end
      mem_ack  = 1'b0;
      was_halt = 1'b1;
    end else if (op == K_LD || op == K_ST) begin
      w = (rst_at >= 0) ? rst_at + 2 : $urandom_range(0, 3);
      for (int k = 0; k <= w; k++) begin
        chk_outs("mem", 1'b1, (op == K_ST), data_addr, 1'b0, 1'b0, 1'b0, 1'b0);
        if (rst_at >= 0 && k == rst_at) begin
          #2 reset = 1'b1;
          #1;
          chk_outs("abort", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
          chk("abort.pc", 32'(pc), 32'h00);
          $display("[TB] pc=%02h instr=%02h reset during MEM wait %0d", at, instr, k);
          return;
        end
        mem_ack   = (k == w);
        mem_rdata = 8'($urandom);
        @(negedge clk);
        cyc++;
      end
      mem_ack = 1'b0;
      if (op == K_LD) begin
        chk_outs("wb", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        mem_ack = 1'($urandom);
        @(negedge clk);
        cyc++;
        mem_ack = 1'b0;
      end
    end else if (op != K_NOP) begin
      chk_outs("exec", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, (op != K_LI), 1'b0);
      mem_ack = 1'($urandom);
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
    end
    $display("[TB] pc=%02h instr=%02h op=%02h cycles=%0d", at, instr, op, cyc);
  endtask

  initial begin
    bit h;
    for (int i = 0; i < 256; i++) mem[i] = rand_instr();
    mem[0] = 8'h0D;  // LI
    mem[1] = 8'h1A;  // ST
    mem[2] = 8'h12;  // LD
    mem[3] = 8'h00;  // NOP

    // Wrap check on the RESET_PC=FF instance (main DUT waits in FETCH meanwhile).
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("ff.rst_pc", 32'(ff_pc), 32'hFF);
    reset = 1'b0;
    @(negedge clk);
    chk("ff.fetch0.req",  32'(ff_mem_req),  32'h1);
    chk("ff.fetch0.addr", 32'(ff_mem_addr), 32'hFF);
    @(negedge clk);
    chk("ff.decode.pc",   32'(ff_pc),       32'h00);
    @(negedge clk);
    chk("ff.fetch1.req",  32'(ff_mem_req),  32'h1);
    chk("ff.fetch1.addr", 32'(ff_mem_addr), 32'h00);
    $display("[TB] RESET_PC=FF instance fetched FF then 00");

    // Random program; more than 256 instructions so the PC wraps.
    do_reset();
    for (int n = 0; n < 300; n++) run_instr(-1, h);

    // HALT, then recovery through reset.
    mem[model_pc] = 8'hF8;
    run_instr(-1, h);
    do_reset();
    for (int n = 0; n < 5; n++) run_instr(-1, h);

    // Reset while a store waits for its ack.
    mem[model_pc] = 8'h1A;
    run_instr(1, h);
    do_reset();
    for (int n = 0; n < 10; n++) run_instr(-1, h);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
